// File: rtl/pd_round_controller.sv
// pd_round_controller: sequences one Prisoner's Dilemma game. It collects a
// decision from each player per round over independent valid/ready
// handshakes, presents the captured pair to the payoff calculator, and
// accumulates the returned points into saturating scores. When the last
// round is scored it reports the winner.
module pd_round_controller #(
  parameter int NUM_ROUNDS = 10,
  parameter int SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dec_a_valid,
  input  logic               dec_b_valid,
  input  logic               dec_a,
  input  logic               dec_b,
  output logic               dec_a_ready,
  output logic               dec_b_ready,
  output logic               decision_a,
  output logic               decision_b,
  input  logic [2:0]         points_a,
  input  logic [2:0]         points_b,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic [7:0]         round_num,
  output logic               round_done,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DEC = 2'd1,
    SCORE    = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [7:0]         ROUNDS_L  = 8'(NUM_ROUNDS);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t     state;
  state_t     state_nxt;
  logic       have_a;
  logic       have_b;
  logic       acc_a;
  logic       acc_b;
  logic       new_game;
  logic [7:0] round_inc;
  logic       last_round;

  // Add a payoff to a score, clamping at the all-ones value instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                 input logic [2:0]         p);
    logic [SCORE_W:0] sum;
    sum = (SCORE_W+1)'(s) + (SCORE_W+1)'(p);
    if (sum[SCORE_W]) return SCORE_MAX;
    return sum[SCORE_W-1:0];
  endfunction

  // A handshake completes only while the player's slot for this round is empty.
  assign acc_a      = dec_a_valid & dec_a_ready;
  assign acc_b      = dec_b_valid & dec_b_ready;
  assign new_game   = start & ((state == IDLE) | (state == DONE));
  assign round_inc  = round_num + 8'd1;
  assign last_round = (round_inc == ROUNDS_L);

  // State register; reset aborts any game in progress immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt   = state;
    dec_a_ready = 1'b0;
    dec_b_ready = 1'b0;
    busy        = 1'b0;
    game_over   = 1'b0;
    winner      = 2'b00;
    case (state)
      IDLE: begin
        if (start) state_nxt = WAIT_DEC;
      end
      WAIT_DEC: begin
        dec_a_ready = ~have_a;
        dec_b_ready = ~have_b;
        busy        = 1'b1;
        if ((have_a | acc_a) & (have_b | acc_b)) state_nxt = SCORE;
      end
      SCORE: begin
        busy      = 1'b1;
        state_nxt = last_round ? DONE : WAIT_DEC;
      end
      DONE: begin
        game_over = 1'b1;
        if (score_a > score_b)      winner = 2'b01;
        else if (score_b > score_a) winner = 2'b10;
        else                        winner = 2'b00;
        if (start) state_nxt = WAIT_DEC;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decision capture, score accumulation and round bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      have_a     <= 1'b0;
      have_b     <= 1'b0;
      decision_a <= 1'b0;
      decision_b <= 1'b0;
      score_a    <= '0;
      score_b    <= '0;
      round_num  <= 8'd0;
      round_done <= 1'b0;
    end else begin
      round_done <= 1'b0;
      if (new_game) begin
        have_a     <= 1'b0;
        have_b     <= 1'b0;
        decision_a <= 1'b0;
        decision_b <= 1'b0;
        score_a    <= '0;
        score_b    <= '0;
        round_num  <= 8'd0;
      end else if (state == WAIT_DEC) begin
        if (acc_a) begin
          decision_a <= dec_a;
          have_a     <= 1'b1;
        end
        if (acc_b) begin
          decision_b <= dec_b;
          have_b     <= 1'b1;
        end
      end else if (state == SCORE) begin
        // points_x is a combinational function of the registered decisions
        score_a    <= sat_add(score_a, points_a);
        score_b    <= sat_add(score_b, points_b);
        round_num  <= round_inc;
        have_a     <= 1'b0;
        have_b     <= 1'b0;
        round_done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pd_round_controller.md
# pd_round_controller

Sequencing stage directly upstream of `payoff_calculator` in the Prisoner's Dilemma game. It runs a game of `NUM_ROUNDS` rounds and collects one decision per player per round through independent valid/ready handshakes. It presents the captured pair to `payoff_calculator` and accumulates the returned points into running scores. When the game ends it declares a winner.

## Interface
- `NUM_ROUNDS`, default 10: rounds per game, legal range 1..255.
- `SCORE_W`, default 8: width of each accumulated score.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; begins a new game, sampled only in IDLE or DONE.
- `dec_a_valid`, `dec_b_valid`  in  1  each player's decision is present.
- `dec_a`, `dec_b`  in  1  0 = cooperate, 1 = defect.
- `dec_a_ready`, `dec_b_ready`  out  1  this player's decision is accepted this cycle.
- `decision_a`, `decision_b`  out  1  registered captured decisions, wired to `payoff_calculator`.
- `points_a`, `points_b`  in  3  from `payoff_calculator`; combinational function of `decision_a`/`decision_b`.
- `score_a`, `score_b`  out  SCORE_W  accumulated scores.
- `round_num`  out  8  rounds completed in the current game.
- `round_done`  out  1  one-cycle pulse after each round is scored.
- `game_over`  out  1  high in DONE.
- `winner`  out  2  valid while `game_over`: 00 tie, 01 A, 10 B, 11 never driven.
- `busy`  out  1  high in WAIT_DEC and SCORE.

## Operation
- States:
  - IDLE: entered on reset.
  - WAIT_DEC: collecting decisions.
  - SCORE: one cycle.
  - DONE: game finished.
- IDLE, `start`=1 → WAIT_DEC. On the same edge, clear scores, `round_num`, and the have_a/have_b flags.
- WAIT_DEC:
  - `dec_a_ready` = !have_a; `dec_b_ready` = !have_b.
  - A handshake (valid & ready) latches the decision into `decision_x` and sets have_x.
  - Players complete in any order and in any cycles. Both in the same cycle is legal.
  - Valid asserted while that player's ready is low is ignored; the decision is not overwritten.
  - When both have flags are set, or will be set by this edge, the next state is SCORE.
- SCORE:
  - Add `points_a`/`points_b` to the scores. Each score saturates at 2^SCORE_W−1.
  - Increment `round_num`, clear the have flags, and register `round_done`=1.
  - If the new `round_num` == NUM_ROUNDS, go to DONE; otherwise go to WAIT_DEC.
- DONE:
  - `game_over`=1. `winner` is from the final scores: A>B → 01, B>A → 10, equal → 00.
  - Scores, `round_num`, and decisions hold.
  - `start`=1 clears everything and goes to WAIT_DEC (new game). There is no pass through IDLE.
- `start` is ignored in WAIT_DEC and SCORE.
- Both readys are low outside WAIT_DEC.

## Timing
- Reset values: state IDLE; all ready, `round_done`, `game_over`, and `busy` at 0; `decision_a`/`decision_b`, scores, `round_num`, and `winner` all 0.
- Reset mid-game aborts immediately and asynchronously to IDLE with the values above.
- Latency, with both valids accepted at edge E0:
  - State is SCORE in cycle E0..E1.
  - Scores and `round_num` update at E1.
  - `round_done`=1 in cycle E1..E2.
  - Readys reassert in cycle E1..E2 (next round).
- Minimum round period is 2 cycles.
- `points_x` must be settled from the registered decisions within the SCORE cycle. No extra pipeline stage.
- Final round: `game_over` rises in the same cycle as the last `round_done`.
- Saturation: if sum > 2^SCORE_W−1, the score is set to 2^SCORE_W−1. There is no wrap.

## Test plan
- Reset, then `start`, then 10 rounds with both players cooperating in the same cycle → `round_done` pulses 10 times; final scores 30/30; `game_over`=1, `winner`=00.
- A defects and B cooperates every round, with A valid 3 cycles before B each round → `dec_a_ready` drops after A's capture while `dec_b_ready` stays high; final scores 50/0; `winner`=01.
- Within one round, A valid with `dec_a`=1 accepted, then `dec_a_valid` held with `dec_a`=0 before B arrives → `decision_a` stays 1; the round scores 5/0 against a cooperating B.
- `NUM_ROUNDS`=10, SCORE_W=5, all A-defect/B-cooperate → `score_a` saturates at 31 from round 7 onward; `score_b`=0.
- `rst` asserted in WAIT_DEC of round 4 → all outputs return to reset values at once; a subsequent `start` begins round 1 with scores 0.
- In DONE, assert `start` → scores and `round_num` clear, `game_over` drops, and `busy`=1 the next cycle. `start` pulsed during WAIT_DEC → no effect on scores or `round_num`.
